// File: rtl/pipe_reg_n_if.sv
// Handshake bus for pipe_reg_n: upstream (in_*) and downstream (out_*) sides of one stage.
// The master modport is the environment that drives beats in and accepts them out.
interface pipe_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
);
    localparam int DW = WIDTH * NCH;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_reg_n.sv
// Multi-channel pipeline register: a two-entry skid stage (SKID=1) or a single-entry stage (SKID=0).
// All channels share one valid bit per entry, so they travel as a single packed word.
module pipe_reg_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int SKID  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    pipe_reg_n_if.slave     bus,
    output logic [1:0]      count
);
    localparam int DW = WIDTH * NCH;

    generate
        if (SKID != 0) begin : g_skid
            // State bits double as the entry valids: bit0 = M.valid, bit1 = S.valid.
            typedef enum logic [1:0] {
                ST_EMPTY = 2'b00,
                ST_ONE   = 2'b01,
                ST_FULL  = 2'b11
            } state_t;

            state_t        r_state;
            state_t        w_nxt_state;
            logic [DW-1:0] r_m_data;
            logic [DW-1:0] r_s_data;
            logic          w_acc;
            logic          w_emit;
            logic          w_ld_m;
            logic          w_m_from_s;
            logic          w_ld_s;

            assign bus.in_ready  = !r_state[1] && !flush;
            assign bus.out_valid = r_state[0];
            assign bus.out_data  = r_m_data;
            assign count         = {r_state[1], r_state[0] & ~r_state[1]};

            assign w_acc  = bus.in_valid && bus.in_ready;
            assign w_emit = r_state[0] && bus.out_ready;

            always_comb begin
                w_nxt_state = r_state;
                w_ld_m      = 1'b0;
                w_m_from_s  = 1'b0;
                w_ld_s      = 1'b0;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_acc) begin
                            w_nxt_state = ST_ONE;
                            w_ld_m      = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (w_acc && w_emit) begin
                            w_ld_m = 1'b1;
                        end else if (w_acc) begin
                            w_nxt_state = ST_FULL;
                            w_ld_s      = 1'b1;
                        end else if (w_emit) begin
                            w_nxt_state = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (w_emit) begin
                            w_nxt_state = ST_ONE;
                            w_m_from_s  = 1'b1;
                        end
                    end
                    default: w_nxt_state = ST_EMPTY;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_state  <= ST_EMPTY;
                    r_m_data <= '0;
                    r_s_data <= '0;
                end else begin
                    r_state <= w_nxt_state;
                    if (w_ld_m)
                        r_m_data <= bus.in_data;
                    else if (w_m_from_s)
                        r_m_data <= r_s_data;
                    if (w_ld_s)
                        r_s_data <= bus.in_data;
                    else if (w_m_from_s)
                        r_s_data <= '0;
                end
            end
        end else begin : g_single
            logic          r_m_vld;
            logic [DW-1:0] r_m_data;
            logic          w_acc;
            logic          w_emit;

            // Refilling in the same cycle as the drain needs out_ready combinationally.
            assign bus.in_ready  = (!r_m_vld || bus.out_ready) && !flush;
            assign bus.out_valid = r_m_vld;
            assign bus.out_data  = r_m_data;
            assign count         = {1'b0, r_m_vld};

            assign w_acc  = bus.in_valid && bus.in_ready;
            assign w_emit = r_m_vld && bus.out_ready;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_m_vld  <= 1'b0;
                    r_m_data <= '0;
                end else if (w_acc) begin
                    r_m_vld  <= 1'b1;
                    r_m_data <= bus.in_data;
                end else if (w_emit) begin
                    r_m_vld  <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: doc/pipe_reg_n.md
PIPE_REG_N -- requirements
Module: pipe_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, bits per channel; legal values >= 1.
REQ-002 Parameter NCH, default 2, number of channels carried together; legal values >= 1.
REQ-003 Parameter SKID, default 1; 1 = two-entry skid stage with full throughput, 0 = single-entry stage.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream offers a beat.
REQ-008 in_ready  output  1  stage accepts a beat this cycle.
REQ-009 in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 out_valid  output  1  stage presents a beat.
REQ-011 out_ready  input  1  downstream accepts a beat.
REQ-012 out_data  output  NCH*WIDTH  same channel packing as in_data.
REQ-013 count  output  2  number of valid entries held, 0..2.

Function
REQ-014 Accept = in_valid && in_ready; emit = out_valid && out_ready; both evaluated in the same cycle.
REQ-015 Storage is a main entry M (data and valid) and, when SKID=1, a skid entry S (data and valid); all channels load, move and clear together.
REQ-016 out_valid = M.valid and out_data = M.data, driven straight from registers with no combinational path from any input.
REQ-017 SKID=1: in_ready = !S.valid && !flush, registered apart from the flush term; there is no combinational path from out_ready.
REQ-018 SKID=1 states: EMPTY (M and S invalid), ONE (M valid, S invalid), FULL (M and S valid); count = 0, 1 and 2 respectively.
REQ-019 EMPTY: accept -> ONE with M <= in_data; otherwise remain EMPTY.
REQ-020 ONE: accept and emit -> ONE with M <= in_data; accept only -> FULL with S <= in_data; emit only -> EMPTY; neither -> ONE.
REQ-021 FULL: in_ready = 0; emit -> ONE with M <= S.data and S cleared; otherwise remain FULL with data unchanged.
REQ-022 SKID=0: in_ready = (!M.valid || out_ready) && !flush, combinational from out_ready; accept -> M <= in_data, valid 1; emit without accept -> M invalid; count ranges 0..1.
REQ-023 flush takes priority over accept and emit: at the next edge all valid bits are 0, all data registers are 0, and count = 0.
REQ-024 A beat presented during a flush cycle is not accepted (in_ready = 0); out_valid in the flush cycle reflects the pre-flush state, and an emit in that cycle counts as a completed transfer.
REQ-025 Data in M or S changes only on a load, flush or reset; held beats are stable while out_ready = 0.
REQ-026 Beats leave in acceptance order with no loss or duplication; the stage reaches full throughput of 1 beat per cycle in steady state.
REQ-027 Latency is 1 cycle: a beat accepted at edge k is visible on out_data after edge k.

Reset
REQ-028 While reset is high at an edge: M and S are cleared (valid 0, data 0); after the edge out_valid = 0, out_data = 0 and count = 0.
REQ-029 reset overrides flush, accept and emit; in_ready after reset is 1 (SKID=1), or 1 when flush = 0 (SKID=0).
REQ-030 Reset asserted mid-transfer discards all held beats; no beat accepted before reset appears afterwards.

Verification
REQ-031 WIDTH=8, NCH=2, SKID=1: reset, then in_data=16'hA55A with in_valid=1 and out_ready=1 for 1 cycle -> out_valid=1, out_data=16'hA55A next cycle, count=1.
REQ-032 SKID=1, out_ready=0: send 16'h0001 then 16'h0002 -> count=2 and in_ready=0; raise out_ready -> outputs 0001 then 0002 on consecutive cycles, count 2->1->0.
REQ-033 SKID=1, in_valid and out_ready held at 1 for 8 beats 0..7 -> 8 outputs in order on 8 consecutive cycles after 1 cycle latency; in_ready stays 1.
REQ-034 SKID=1 FULL with flush=1 and in_valid=1 in the same cycle -> in_ready=0 that cycle; next cycle out_valid=0, out_data=0, count=0, offered beat absent.
REQ-035 SKID=0: M valid, out_ready=0 -> in_ready=0; out_ready=1 with in_valid=1 -> emit and accept in the same cycle, count stays 1.
REQ-036 Reset asserted with count=2 and flush=1 -> next cycle count=0, out_valid=0, out_data=0; no earlier beat reappears.
